if_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register directly upstream of the control decoder.
- Holds the PC and fetches one instruction at a time from instruction memory over a request/grant/response handshake with variable latency.
- Registers the fetched word and PC+4, and presents the opcode field op[5:0] to the control unit.
- Handles hazard stalls, flushes and taken-branch redirects, including responses that were already in flight when the redirect arrived.

---
 rtl/if_stage_pkg.sv | 22 ++
 rtl/if_id_reg.sv | 56 +++++
 rtl/if_stage.sv | 154 +++++++++++++++
 tb/tb_if_stage.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: opcode field position,
// the NOP encoding used for IF/ID bubbles and the fetch FSM state encoding.
package if_stage_pkg;

    // Opcode field handed to the control decoder.
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;

    // An all-zero word is a bubble as far as the decoder is concerned.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Fetch FSM states.
    localparam logic [1:0] S_REQ  = 2'd0;  // presenting a request
    localparam logic [1:0] S_WAIT = 2'd1;  // one request outstanding
    localparam logic [1:0] S_HOLD = 2'd2;  // response parked in the skid buffer

    // Opcode field of an instruction word.
    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: reset, then flush (bubble), then a load
// that is not blocked by stall; otherwise the contents are held.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                stall,
    input  logic                load,
    input  logic [31:0]         load_instr,
    input  logic [PC_WIDTH-1:0] load_pc4,
    output logic                valid,
    output logic [31:0]         instr,
    output logic [PC_WIDTH-1:0] pc4
);

    logic                valid_q, valid_d;
    logic [31:0]         instr_q, instr_d;
    logic [PC_WIDTH-1:0] pc4_q, pc4_d;

    // Next-state selection: flush beats load, stall holds.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        if (flush) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (load && !stall) begin
            valid_d = 1'b1;
            instr_d = load_instr;
            pc4_d   = load_pc4;
        end
    end

    // Register update with synchronous reset to an empty, all-zero stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc4   = pc4_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding fetch FSM, skid buffer for
// responses that arrive during a stall, and the IF/ID register feeding the
// control decoder.
//
// Memory handshake: a request transfers on a rising edge where
// imem_req && imem_gnt; imem_addr is only meaningful while imem_req is high.
// Every transferred request is answered by exactly one imem_rvalid pulse in a
// later cycle, and imem_rvalid is accepted unconditionally (no back-pressure),
// which is why a stalled response is parked in the skid buffer.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output logic                if_id_valid,
    output logic [31:0]         if_id_instr,
    output logic [PC_WIDTH-1:0] if_id_pc4,
    output logic [5:0]          op,
    output logic [1:0]          dbg_state
);

    localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

    logic [1:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] pc_inflight_q, pc_inflight_d;
    logic                kill_q, kill_d;
    logic [31:0]         skid_q, skid_d;

    logic                id_load;
    logic [31:0]         id_load_instr;
    logic [PC_WIDTH-1:0] next_seq_pc;
    logic                reset_mid_wait;

    // Sequential successor of the instruction being fetched (wraps mod 2^W).
    assign next_seq_pc = pc_inflight_q + PC_STEP;

    // No request leaves the stage during a reset cycle.
    assign imem_req  = (state_q == S_REQ) && !reset;
    assign imem_addr = pc_q;
    assign dbg_state = state_q;

    // A reset while a response is still owed must swallow that response, so
    // the FSM restarts waiting for it with kill set. If it arrives in the
    // reset cycle itself it is already gone and a plain restart is safe.
    assign reset_mid_wait = (state_q == S_WAIT) && !imem_rvalid;

    // Fetch FSM, PC and skid buffer next-state logic.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_inflight_d = pc_inflight_q;
        kill_d        = kill_q;
        skid_d        = skid_q;
        id_load       = 1'b0;
        id_load_instr = skid_q;

        case (state_q)
            S_REQ: begin
                if (imem_gnt) begin
                    pc_inflight_d = pc_q;
                    state_d       = S_WAIT;
                    // A redirect in the grant cycle makes this fetch stale.
                    kill_d        = branch_taken;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                    if (kill_q) begin
                        kill_d = 1'b0;
                    end else if (!branch_taken) begin
                        if (!stall) begin
                            id_load       = 1'b1;
                            id_load_instr = imem_rdata;
                            pc_d          = next_seq_pc;
                        end else begin
                            skid_d  = imem_rdata;
                            state_d = S_HOLD;
                        end
                    end
                end else if (branch_taken) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    state_d = S_REQ;
                end else if (!stall) begin
                    id_load = 1'b1;
                    pc_d    = next_seq_pc;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        // Redirect overrides any sequential PC update.
        if (branch_taken) begin
            pc_d = branch_target & ALIGN_MASK;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            pc_inflight_q <= RESET_PC;
            skid_q        <= NOP_INSTR;
            state_q       <= reset_mid_wait ? S_WAIT : S_REQ;
            kill_q        <= reset_mid_wait;
        end else begin
            pc_q          <= pc_d;
            pc_inflight_q <= pc_inflight_d;
            skid_q        <= skid_d;
            state_q       <= state_d;
            kill_q        <= kill_d;
        end
    end

    if_id_reg #(
        .PC_WIDTH (PC_WIDTH)
    ) u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush || branch_taken),
        .stall      (stall),
        .load       (id_load),
        .load_instr (id_load_instr),
        .load_pc4   (next_seq_pc),
        .valid      (if_id_valid),
        .instr      (if_id_instr),
        .pc4        (if_id_pc4)
    );

    // Decoder opcode; reads 0 for a bubble because IF/ID then holds NOP.
    assign op = opcode_of(if_id_instr);

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by a randomized run checked
// against a transaction-level fetch model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, branch_taken;
    logic [31:0] branch_target;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_instr, if_id_pc4;
    logic [5:0]  op;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    if_stage #(
        .PC_WIDTH (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .op            (op),
        .dbg_state     (dbg_state)
    );

    // ---------------- memory model ----------------
    int          gnt_prob = 100;
    int          lat_min  = 0;
    int          lat_max  = 0;
    bit          pend     = 1'b0;
    logic [31:0] pend_addr;
    int          pend_lat;
    logic [15:0] seq = 16'h0001;
    logic [31:0] last_rdata = 32'h0;
    logic [31:0] dmem [logic [31:0]];

    // Drive the memory side for the coming edge and account for it.
    task automatic mem_drive();
        bit was_pend;
        was_pend    = pend;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (pend) begin
            if (pend_lat == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = dmem.exists(pend_addr) ? dmem[pend_addr] : {seq, pend_addr[15:0]};
                last_rdata  = imem_rdata;
                seq++;
                pend = 1'b0;
            end else begin
                pend_lat--;
            end
        end
        imem_gnt = ($urandom_range(0, 99) < gnt_prob);
        if (imem_req && imem_gnt) begin
            n_checks++;
            if (was_pend) begin
                n_fail++;
                $display("FAIL one_outstanding: got request at %h expected none while a response is owed", imem_addr);
            end
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_lat  = $urandom_range(lat_min, lat_max);
        end
    endtask

    // One clock cycle: memory drives at negedge, outputs sampled 1 after posedge.
    task automatic cycle();
        @(negedge clk);
        mem_drive();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0; gnt_prob = 100; lat_min = 0; lat_max = 0;
        cycle();
        cycle();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %h expected 0", imem_req); end
        n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %h expected 0", if_id_valid); end
        n_checks++; if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", if_id_instr); end
        n_checks++; if (if_id_pc4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4: got %h expected 0", if_id_pc4); end
        n_checks++; if (op !== 6'h0) begin n_fail++; $display("FAIL reset_op: got %h expected 0", op); end
        reset = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_first_req: got %h expected 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_first_addr: got %h expected 0", imem_addr); end
    endtask

    task automatic test_first_fetch();
        dmem[32'h0] = 32'h8C08_0004;
        cycle();  // grant
        n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL ff_wait_valid: got %h expected 0", if_id_valid); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL ff_wait_req: got %h expected 0", imem_req); end
        cycle();  // response
        n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL ff_valid: got %h expected 1", if_id_valid); end
        n_checks++; if (if_id_instr !== 32'h8C08_0004) begin n_fail++; $display("FAIL ff_instr: got %h expected 8c080004", if_id_instr); end
        n_checks++; if (op !== 6'd35) begin n_fail++; $display("FAIL ff_op: got %0d expected 35", op); end
        n_checks++; if (if_id_pc4 !== 32'h4) begin n_fail++; $display("FAIL ff_pc4: got %h expected 4", if_id_pc4); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL ff_next_addr: got req=%h addr=%h expected req=1 addr=4", imem_req, imem_addr); end
    endtask

    task automatic test_stall();
        dmem[32'h4] = 32'h2001_0004;
        dmem[32'h8] = 32'h1000_0003;
        cycle(); cycle();  // fetch 0x4
        n_checks++; if (if_id_pc4 !== 32'h8) begin n_fail++; $display("FAIL st_pre_pc4: got %h expected 8", if_id_pc4); end
        cycle();           // grant 0x8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++; if (if_id_instr !== 32'h2001_0004 || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL st_hold_instr: got %h/%h expected 20010004/1", if_id_instr, if_id_valid); end
            n_checks++; if (if_id_pc4 !== 32'h8) begin n_fail++; $display("FAIL st_hold_pc4: got %h expected 8", if_id_pc4); end
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL st_hold_req: got %h expected 0", imem_req); end
        end
        stall = 1'b0;
        cycle();
        n_checks++; if (if_id_instr !== 32'h1000_0003) begin n_fail++; $display("FAIL st_rel_instr: got %h expected 10000003", if_id_instr); end
        n_checks++; if (if_id_pc4 !== 32'hC) begin n_fail++; $display("FAIL st_rel_pc4: got %h expected c", if_id_pc4); end
        n_checks++; if (op !== 6'd4) begin n_fail++; $display("FAIL st_rel_op: got %0d expected 4", op); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_fail++; $display("FAIL st_next_addr: got req=%h addr=%h expected req=1 addr=c", imem_req, imem_addr); end
    endtask

    task automatic test_branch_wait();
        dmem[32'hC] = 32'h2002_000C;
        cycle(); cycle();  // fetch 0xC
        n_checks++; if (if_id_pc4 !== 32'h10) begin n_fail++; $display("FAIL bw_pre_pc4: got %h expected 10", if_id_pc4); end
        lat_min = 2; lat_max = 2;
        cycle();           // grant 0x10, response two cycles late
        branch_taken = 1'b1; branch_target = 32'h41;
        cycle();
        branch_taken = 1'b0;
        n_checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin n_fail++; $display("FAIL bw_flush: got %h/%h expected 0/0", if_id_valid, if_id_instr); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bw_wait_req: got %h expected 0", imem_req); end
        for (int i = 0; i < 10 && !imem_req; i++) cycle();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL bw_redirect: got req=%h addr=%h expected req=1 addr=40", imem_req, imem_addr); end
        n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL bw_dropped: got %h expected 0", if_id_valid); end
        lat_min = 0; lat_max = 0;
    endtask

    task automatic test_grant_branch();
        dmem[32'h100] = 32'hAC0A_0100;
        branch_taken = 1'b1; branch_target = 32'h100;
        cycle();           // grant of 0x40 coincides with redirect
        branch_taken = 1'b0;
        n_checks++; if (imem_req !== 1'b0 || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL gb_wait: got req=%h valid=%h expected 0/0", imem_req, if_id_valid); end
        cycle();           // stale response
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL gb_addr: got req=%h addr=%h expected req=1 addr=100", imem_req, imem_addr); end
        n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL gb_dropped: got %h expected 0", if_id_valid); end
        cycle(); cycle();
        n_checks++; if (if_id_instr !== 32'hAC0A_0100 || if_id_pc4 !== 32'h104) begin n_fail++; $display("FAIL gb_load: got %h/%h expected ac0a0100/104", if_id_instr, if_id_pc4); end
        n_checks++; if (op !== 6'd43) begin n_fail++; $display("FAIL gb_op: got %0d expected 43", op); end
    endtask

    task automatic test_flush();
        dmem[32'h1C] = 32'h3C01_001C;
        gnt_prob = 0;
        branch_taken = 1'b1; branch_target = 32'h1C;
        cycle();
        branch_taken = 1'b0;
        gnt_prob = 100;
        n_checks++; if (imem_addr !== 32'h1C) begin n_fail++; $display("FAIL fl_redirect: got %h expected 1c", imem_addr); end
        cycle(); cycle();
        n_checks++; if (if_id_valid !== 1'b1 || if_id_pc4 !== 32'h20 || op !== 6'd15) begin n_fail++; $display("FAIL fl_pre: got %h/%h/%0d expected 1/20/15", if_id_valid, if_id_pc4, op); end
        cycle();           // grant 0x20
        flush = 1'b1;
        cycle();           // response coincides with flush
        flush = 1'b0;
        n_checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || op !== 6'h0) begin n_fail++; $display("FAIL fl_bubble: got %h/%h/%h expected 0/0/0", if_id_valid, if_id_instr, op); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h24) begin n_fail++; $display("FAIL fl_pc: got req=%h addr=%h expected req=1 addr=24", imem_req, imem_addr); end
    endtask

    task automatic test_reset_inflight();
        lat_min = 2; lat_max = 2;
        cycle();           // grant 0x24, response still owed
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL ri_req: got %h expected 0", imem_req); end
        for (int i = 0; i < 10 && !imem_req; i++) begin
            cycle();
            n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL ri_stale: got %h expected 0", if_id_valid); end
        end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL ri_restart: got req=%h addr=%h expected req=1 addr=0", imem_req, imem_addr); end
        lat_min = 0; lat_max = 0;
        cycle(); cycle();
        n_checks++; if (if_id_instr !== 32'h8C08_0004 || if_id_pc4 !== 32'h4) begin n_fail++; $display("FAIL ri_fetch: got %h/%h expected 8c080004/4", if_id_instr, if_id_pc4); end
    endtask

    task automatic test_wrap();
        gnt_prob = 0;
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
        cycle();
        branch_taken = 1'b0;
        gnt_prob = 100;
        n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_align: got %h expected fffffffc", imem_addr); end
        cycle(); cycle();
        n_checks++; if (if_id_valid !== 1'b1 || if_id_instr[15:0] !== 16'hFFFC) begin n_fail++; $display("FAIL wr_load: got %h/%h expected 1/....fffc", if_id_valid, if_id_instr); end
        n_checks++; if (if_id_pc4 !== 32'h0) begin n_fail++; $display("FAIL wr_pc4: got %h expected 0", if_id_pc4); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wr_next: got %h expected 0", imem_addr); end
    endtask

    // Randomized run. The model knows only that loads appear in program order
    // starting from the last redirect, that each loaded word is the latest
    // word the memory delivered, and that stalls and redirects freeze/clear IF/ID.
    task automatic test_random();
        logic [31:0] exp_q[$];
        logic [31:0] exp_addr;
        logic [31:0] model_instr;
        logic [31:0] tgt;
        bit          model_valid;
        bit          do_br;
        bit          do_stall;
        int          n_loads = 0;
        dmem.delete();
        exp_q.push_back(32'h0);
        model_instr = last_rdata;
        model_valid = 1'b1;
        gnt_prob = 70; lat_min = 0; lat_max = 3;
        for (int c = 0; c < 2000; c++) begin
            do_stall      = ($urandom_range(0, 99) < 25);
            do_br         = ($urandom_range(0, 99) < 4);
            tgt           = 32'($urandom_range(0, 32'h3FF));
            stall         = do_stall;
            branch_taken  = do_br;
            branch_target = tgt;
            cycle();
            if (do_br) begin
                n_checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin n_fail++; $display("FAIL rnd_branch_flush: got %h/%h expected 0/0", if_id_valid, if_id_instr); end
                model_valid = 1'b0;
                model_instr = 32'h0;
                exp_q.delete();
                exp_q.push_back(tgt & 32'hFFFF_FFFC);
            end else if (if_id_instr !== model_instr) begin
                n_loads++;
                exp_addr = exp_q.pop_front();
                n_checks++; if (do_stall) begin n_fail++; $display("FAIL rnd_load_in_stall: got load of %h expected hold", if_id_instr); end
                n_checks++; if (if_id_instr !== last_rdata || if_id_instr[15:0] !== exp_addr[15:0]) begin n_fail++; $display("FAIL rnd_instr: got %h expected %h (addr %h)", if_id_instr, last_rdata, exp_addr); end
                n_checks++; if (if_id_pc4 !== exp_addr + 32'h4 || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL rnd_pc4: got %h/%h expected %h/1", if_id_pc4, if_id_valid, exp_addr + 32'h4); end
                n_checks++; if (op !== last_rdata[31:26]) begin n_fail++; $display("FAIL rnd_op: got %h expected %h", op, last_rdata[31:26]); end
                model_instr = last_rdata;
                model_valid = 1'b1;
                exp_q.push_back(exp_addr + 32'h4);
            end else begin
                n_checks++; if (if_id_valid !== model_valid) begin n_fail++; $display("FAIL rnd_hold_valid: got %h expected %h", if_id_valid, model_valid); end
            end
        end
        stall = 1'b0;
        branch_taken = 1'b0;
        n_checks++; if (n_loads < 100) begin n_fail++; $display("FAIL rnd_progress: got %0d loads expected at least 100", n_loads); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        test_reset();
        test_first_fetch();
        test_stall();
        test_branch_wait();
        test_grant_branch();
        test_flush();
        test_reset_inflight();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog: a hung run still ends with a report.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
